// File: rtl/axil_ram_pkg.sv
// Shared types and address helper for the AXI4-Lite scratch RAM.
// Bounds checking is enabled by defining AXIL_RAM_BOUNDS_CHECK_EN.
package axil_ram_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } resp_t;

    typedef enum logic {
        W_IDLE,
        W_RESP
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_READ,
        R_RESP
    } rd_state_t;

    // Full word address of (addr + offset); the 32-bit sum wraps naturally.
    function automatic logic [31:0] word_idx(input logic [31:0] addr,
                                             input logic [31:0] offset,
                                             input int unsigned lsb);
        logic [31:0] byte_addr;
        byte_addr = addr + offset;
        return byte_addr >> lsb;
    endfunction

endpackage

// File: rtl/axil_ram_if.sv
// AXI4-Lite bundle with master (m) and slave (s) views.
interface axi4_lite_if
    import axil_ram_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    resp_t               bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    resp_t               rresp;
    logic                rvalid;
    logic                rready;

    modport m (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport s (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axil_ram_bram.sv
// Simple dual-port RAM: byte-enabled write port, registered read-first read port.
module axil_ram_bram #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 1024,
    parameter     INIT_FILE = ""
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_W/8-1:0]      wstrb,
    input  logic [DATA_W-1:0]        wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_W-1:0]        rdata
);
    localparam int STRB_W = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: the array has no reset branch so it maps onto block RAM; contents
    // survive reset. Non-blocking updates make a same-edge read see old data.
    always_ff @(posedge clk) begin
        for (int b = 0; b < STRB_W; b++) begin
            if (we && wstrb[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/axil_ram.sv
// AXI4-Lite slave RAM with runtime byte offset and independent AW/W capture.
// Define AXIL_RAM_BOUNDS_CHECK_EN to reject out-of-range accesses with SLVERR.
module axil_ram
    import axil_ram_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 1024,
    parameter     INIT_FILE = ""
) (
    input  logic        aclk,
    input  logic        areset,
    axi4_lite_if.s      axi,
    input  logic [31:0] offset
);
    localparam int LSB    = $clog2(DATA_W / 8);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int STRB_W = DATA_W / 8;

    wr_state_t wr_state, wr_next;
    rd_state_t rd_state, rd_next;

    logic              aw_held, w_held;
    logic [31:0]       aw_word_q;
    logic [DATA_W-1:0] wdata_q;
    logic [STRB_W-1:0] wstrb_q;
    resp_t             bresp_q;
    logic [IDX_W-1:0]  ar_idx_q;
    logic              rd_err_q;

    logic              aw_fire, w_fire, b_fire, ar_fire, r_fire, commit;
    logic              wr_err, ar_err;
    logic [31:0]       aw_word, ar_word;
    logic [DATA_W-1:0] wr_data, ram_rdata;
    logic [STRB_W-1:0] wr_strb;
    logic              unused_ok;

    // Every output is forced idle while reset is asserted.
    assign axi.awready = ~areset & (wr_state == W_IDLE) & ~aw_held;
    assign axi.wready  = ~areset & (wr_state == W_IDLE) & ~w_held;
    assign axi.bvalid  = ~areset & (wr_state == W_RESP);
    assign axi.bresp   = areset ? OKAY : bresp_q;
    assign axi.arready = ~areset & (rd_state == R_IDLE);
    assign axi.rvalid  = ~areset & (rd_state == R_RESP);
    assign axi.rresp   = (axi.rvalid && rd_err_q) ? SLVERR : OKAY;
    assign axi.rdata   = (axi.rvalid && !rd_err_q) ? ram_rdata : '0;

    assign aw_fire = axi.awvalid & axi.awready;
    assign w_fire  = axi.wvalid & axi.wready;
    assign b_fire  = axi.bvalid & axi.bready;
    assign ar_fire = axi.arvalid & axi.arready;
    assign r_fire  = axi.rvalid & axi.rready;

    // A half that arrives this cycle is forwarded so the write commits on its handshake edge.
    assign aw_word = aw_held ? aw_word_q : word_idx(axi.awaddr, offset, LSB);
    assign wr_data = w_held ? wdata_q : axi.wdata;
    assign wr_strb = w_held ? wstrb_q : axi.wstrb;
    assign ar_word = word_idx(axi.araddr, offset, LSB);
    assign commit  = ~areset & (wr_state == W_IDLE) & (aw_held | aw_fire) & (w_held | w_fire);

`ifdef AXIL_RAM_BOUNDS_CHECK_EN
    assign wr_err = (aw_word >= 32'(DEPTH));
    assign ar_err = (ar_word >= 32'(DEPTH));
`else
    assign wr_err = 1'b0;
    assign ar_err = 1'b0;
`endif

    assign unused_ok = ^{axi.awprot, axi.arprot, aw_word[31:IDX_W], ar_word[31:IDX_W]};

    // NOTE: two-process FSM; every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        wr_next = wr_state;
        unique case (wr_state)
            W_IDLE:  if (commit) wr_next = W_RESP;
            W_RESP:  if (b_fire) wr_next = W_IDLE;
            default: wr_next = W_IDLE;
        endcase
    end

    always_comb begin
        rd_next = rd_state;
        unique case (rd_state)
            R_IDLE:  if (ar_fire) rd_next = R_READ;
            R_READ:  rd_next = R_RESP;
            R_RESP:  if (r_fire) rd_next = R_IDLE;
            default: rd_next = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_state <= W_IDLE;
            rd_state <= R_IDLE;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            bresp_q  <= OKAY;
            rd_err_q <= 1'b0;
        end else begin
            wr_state <= wr_next;
            rd_state <= rd_next;
            if (aw_fire) aw_held <= 1'b1;
            if (w_fire)  w_held  <= 1'b1;
            if (b_fire) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
            end
            if (commit)  bresp_q  <= wr_err ? SLVERR : OKAY;
            if (ar_fire) rd_err_q <= ar_err;
        end
    end

    // Payload registers are qualified by the held flags and need no reset.
    always_ff @(posedge aclk) begin
        if (aw_fire) aw_word_q <= aw_word;
        if (w_fire) begin
            wdata_q <= axi.wdata;
            wstrb_q <= axi.wstrb;
        end
        if (ar_fire) ar_idx_q <= ar_word[IDX_W-1:0];
    end

    axil_ram_bram #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .INIT_FILE(INIT_FILE)
    ) u_bram (
        .clk  (aclk),
        .we   (commit & ~wr_err),
        .waddr(aw_word[IDX_W-1:0]),
        .wstrb(wr_strb),
        .wdata(wr_data),
        .re   (~areset & (rd_state == R_READ)),
        .raddr(ar_idx_q),
        .rdata(ram_rdata)
    );

endmodule

// File: tb/tb_axil_ram.sv
// Directed self-checking bench for axil_ram (DATA_W=32, DEPTH=1024).
module tb_axil_ram;
    import axil_ram_pkg::*;

    localparam int BUDGET = 20;

    logic        aclk = 1'b0;
    logic        areset;
    logic [31:0] offset;
    int          n_cmp = 0;
    int          n_err = 0;

    axi4_lite_if #(.DATA_W(32), .ADDR_W(32)) axi ();

    axil_ram #(
        .DATA_W   (32),
        .DEPTH    (1024),
        .INIT_FILE("")
    ) dut (
        .aclk  (aclk),
        .areset(areset),
        .axi   (axi.s),
        .offset(offset)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic bus_idle();
        axi.awaddr = '0; axi.awprot = '0; axi.awvalid = 1'b0;
        axi.wdata = '0;  axi.wstrb = '0;  axi.wvalid = 1'b0;
        axi.bready = 1'b0;
        axi.araddr = '0; axi.arprot = '0; axi.arvalid = 1'b0;
        axi.rready = 1'b0;
    endtask

    task automatic do_write(input string tag, input logic [31:0] addr, input logic [31:0] off,
                            input logic [31:0] data, input logic [3:0] strb,
                            input logic [1:0] exp_resp);
        int n;
        @(posedge aclk); #1;
        axi.awaddr = addr; offset = off; axi.wdata = data; axi.wstrb = strb;
        axi.awvalid = 1'b1; axi.wvalid = 1'b1;
        n = 0;
        @(negedge aclk);
        while (!(axi.awready && axi.wready) && n < BUDGET) begin
            n++;
            @(negedge aclk);
        end
        check({tag, "_aw_w_accept"}, 64'(n < BUDGET), 64'd1);
        @(posedge aclk); #1;
        axi.awvalid = 1'b0; axi.wvalid = 1'b0;
        @(negedge aclk);
        check({tag, "_bvalid"}, 64'(axi.bvalid), 64'd1);
        check({tag, "_bresp"}, 64'(axi.bresp), 64'(exp_resp));
        axi.bready = 1'b1;
        @(posedge aclk); #1;
        axi.bready = 1'b0;
    endtask

    task automatic do_read(input string tag, input logic [31:0] addr, input logic [31:0] off,
                           input logic [31:0] exp_data, input logic [1:0] exp_resp);
        int n;
        @(posedge aclk); #1;
        axi.araddr = addr; offset = off; axi.arvalid = 1'b1;
        n = 0;
        @(negedge aclk);
        while (!axi.arready && n < BUDGET) begin
            n++;
            @(negedge aclk);
        end
        check({tag, "_ar_accept"}, 64'(n < BUDGET), 64'd1);
        @(posedge aclk); #1;
        axi.arvalid = 1'b0;
        @(negedge aclk);
        check({tag, "_rvalid_t1"}, 64'(axi.rvalid), 64'd0);
        @(negedge aclk);
        check({tag, "_rvalid_t2"}, 64'(axi.rvalid), 64'd1);
        check({tag, "_rdata"}, 64'(axi.rdata), 64'(exp_data));
        check({tag, "_rresp"}, 64'(axi.rresp), 64'(exp_resp));
        axi.rready = 1'b1;
        @(posedge aclk); #1;
        axi.rready = 1'b0;
    endtask

    initial begin
        areset = 1'b1;
        offset = '0;
        bus_idle();

        // Reset state
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("rst_awready", 64'(axi.awready), 64'd0);
        check("rst_wready",  64'(axi.wready),  64'd0);
        check("rst_arready", 64'(axi.arready), 64'd0);
        check("rst_bvalid",  64'(axi.bvalid),  64'd0);
        check("rst_rvalid",  64'(axi.rvalid),  64'd0);
        check("rst_bresp",   64'(axi.bresp),   64'd0);
        check("rst_rresp",   64'(axi.rresp),   64'd0);
        check("rst_rdata",   64'(axi.rdata),   64'd0);
        @(posedge aclk); #1;
        areset = 1'b0;
        @(negedge aclk);
        check("post_rst_awready", 64'(axi.awready), 64'd1);
        check("post_rst_wready",  64'(axi.wready),  64'd1);
        check("post_rst_arready", 64'(axi.arready), 64'd1);

        // Offset added to the address; both aliases of byte 0x100 read back
        do_write("t1_wr", 32'h0, 32'h100, 32'hDEAD_BEEF, 4'hF, 2'b00);
        do_read("t1_rd_off", 32'h0,   32'h100, 32'hDEAD_BEEF, 2'b00);
        do_read("t1_rd_abs", 32'h100, 32'h0,   32'hDEAD_BEEF, 2'b00);

        // Offset wrap: 0xFFFFFF00 + 0x208 = 0x108 -> word 0x42
        do_write("wrap_wr", 32'hFFFF_FF00, 32'h208, 32'h0000_A5A5, 4'hF, 2'b00);
        do_read("wrap_rd", 32'h108, 32'h0, 32'h0000_A5A5, 2'b00);

        // W accepted three cycles ahead of AW
        @(posedge aclk); #1;
        offset = '0; axi.wdata = 32'hCAFE_F00D; axi.wstrb = 4'hF; axi.wvalid = 1'b1;
        @(negedge aclk);
        check("t2_wready_pre", 64'(axi.wready), 64'd1);
        @(posedge aclk); #1;
        axi.wvalid = 1'b0;
        @(negedge aclk);
        check("t2_wready_held",  64'(axi.wready),  64'd0);
        check("t2_awready_open", 64'(axi.awready), 64'd1);
        check("t2_no_bvalid",    64'(axi.bvalid),  64'd0);
        repeat (2) @(posedge aclk);
        #1;
        axi.awaddr = 32'h20; axi.awvalid = 1'b1;
        @(negedge aclk);
        check("t2_awready", 64'(axi.awready), 64'd1);
        @(posedge aclk); #1;
        axi.awvalid = 1'b0;
        @(negedge aclk);
        check("t2_bvalid", 64'(axi.bvalid), 64'd1);
        check("t2_bresp",  64'(axi.bresp),  64'd0);
        axi.bready = 1'b1;
        @(posedge aclk); #1;
        axi.bready = 1'b0;
        do_read("t2_rd", 32'h20, 32'h0, 32'hCAFE_F00D, 2'b00);

        // Partial strobe over an existing word
        do_write("t3_full", 32'h0, 32'h0, 32'hDEAD_BEEF, 4'hF, 2'b00);
        do_write("t3_part", 32'h0, 32'h0, 32'h1234_5678, 4'h3, 2'b00);
        do_read("t3_rd", 32'h0, 32'h0, 32'hDEAD_5678, 2'b00);

        // Both responses stalled for five cycles
        @(posedge aclk); #1;
        offset = '0;
        axi.awaddr = 32'h30; axi.wdata = 32'h1111_2222; axi.wstrb = 4'hF;
        axi.araddr = 32'h100;
        axi.awvalid = 1'b1; axi.wvalid = 1'b1; axi.arvalid = 1'b1;
        @(posedge aclk); #1;
        axi.awvalid = 1'b0; axi.wvalid = 1'b0; axi.arvalid = 1'b0;
        repeat (2) @(negedge aclk);
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            check("t4_bvalid",  64'(axi.bvalid),  64'd1);
            check("t4_rvalid",  64'(axi.rvalid),  64'd1);
            check("t4_rdata",   64'(axi.rdata),   64'hDEAD_BEEF);
            check("t4_bresp",   64'(axi.bresp),   64'd0);
            check("t4_rresp",   64'(axi.rresp),   64'd0);
            check("t4_awready", 64'(axi.awready), 64'd0);
            check("t4_wready",  64'(axi.wready),  64'd0);
            check("t4_arready", 64'(axi.arready), 64'd0);
        end
        axi.bready = 1'b1;
        @(posedge aclk); #1;
        axi.bready = 1'b0;
        @(negedge aclk);
        check("t4_b_done",      64'(axi.bvalid),  64'd0);
        check("t4_awready_new", 64'(axi.awready), 64'd1);
        check("t4_wready_new",  64'(axi.wready),  64'd1);
        check("t4_rvalid_hold", 64'(axi.rvalid),  64'd1);
        axi.rready = 1'b1;
        @(posedge aclk); #1;
        axi.rready = 1'b0;
        @(negedge aclk);
        check("t4_r_done",      64'(axi.rvalid),  64'd0);
        check("t4_arready_new", 64'(axi.arready), 64'd1);
        do_read("t4_wr_chk", 32'h30, 32'h0, 32'h1111_2222, 2'b00);

        // Same-word collision: read issued on the commit edge returns old data
        do_write("col_init", 32'h140, 32'h0, 32'h0101_0101, 4'hF, 2'b00);
        @(posedge aclk); #1;
        offset = '0; axi.araddr = 32'h140; axi.arvalid = 1'b1;
        @(posedge aclk); #1;
        axi.arvalid = 1'b0;
        axi.awaddr = 32'h140; axi.wdata = 32'h0202_0202; axi.wstrb = 4'hF;
        axi.awvalid = 1'b1; axi.wvalid = 1'b1;
        @(posedge aclk); #1;
        axi.awvalid = 1'b0; axi.wvalid = 1'b0;
        @(negedge aclk);
        check("col_bvalid", 64'(axi.bvalid), 64'd1);
        check("col_rvalid", 64'(axi.rvalid), 64'd1);
        check("col_rdata",  64'(axi.rdata),  64'h0101_0101);
        axi.bready = 1'b1; axi.rready = 1'b1;
        @(posedge aclk); #1;
        axi.bready = 1'b0; axi.rready = 1'b0;
        do_read("col_after", 32'h140, 32'h0, 32'h0202_0202, 2'b00);

        // Out-of-range access at byte 0x1000
`ifdef AXIL_RAM_BOUNDS_CHECK_EN
        do_write("t5_wr", 32'h1000, 32'h0, 32'h55AA_55AA, 4'hF, 2'b10);
        do_read("t5_rd_oob", 32'h1000, 32'h0, 32'h0, 2'b10);
        do_read("t5_rd_w0",  32'h0,    32'h0, 32'hDEAD_5678, 2'b00);
`else
        do_write("t5_wr", 32'h1000, 32'h0, 32'h55AA_55AA, 4'hF, 2'b00);
        do_read("t5_rd_alias", 32'h1000, 32'h0, 32'h55AA_55AA, 2'b00);
        do_read("t5_rd_w0",    32'h0,    32'h0, 32'h55AA_55AA, 2'b00);
`endif

        // Reset while in W_RESP and R_READ
        @(posedge aclk); #1;
        offset = '0;
        axi.awaddr = 32'h180; axi.wdata = 32'h7777_8888; axi.wstrb = 4'hF;
        axi.araddr = 32'h180;
        axi.awvalid = 1'b1; axi.wvalid = 1'b1; axi.arvalid = 1'b1;
        @(posedge aclk); #1;
        axi.awvalid = 1'b0; axi.wvalid = 1'b0; axi.arvalid = 1'b0;
        areset = 1'b1;
        @(negedge aclk);
        check("t6_rst_bvalid",  64'(axi.bvalid),  64'd0);
        check("t6_rst_rvalid",  64'(axi.rvalid),  64'd0);
        check("t6_rst_awready", 64'(axi.awready), 64'd0);
        check("t6_rst_arready", 64'(axi.arready), 64'd0);
        @(posedge aclk); #1;
        areset = 1'b0;
        @(negedge aclk);
        check("t6_awready", 64'(axi.awready), 64'd1);
        check("t6_wready",  64'(axi.wready),  64'd1);
        check("t6_arready", 64'(axi.arready), 64'd1);
        for (int i = 0; i < 4; i++) begin
            check("t6_no_bvalid", 64'(axi.bvalid), 64'd0);
            check("t6_no_rvalid", 64'(axi.rvalid), 64'd0);
            @(negedge aclk);
        end
        do_read("t6_committed", 32'h180, 32'h0, 32'h7777_8888, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
